// File: rtl/uart_seq_pkg.sv
// Shared state encoding and default widths for the UART byte-stream sequencer.
// No logic here, so there is no latency and no backpressure.
package uart_seq_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 32;
   localparam int GAP_W_DEF  = 8;
   localparam int TMO_W_DEF  = 16;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      REQ,
      WAIT,
      ADV,
      GAP
   } seq_state_t;
endpackage

// File: rtl/seq_buffer.sv
// Simple dual-port byte buffer: synchronous write, registered read (1 cycle), no backpressure.
// Not reset, so it maps onto block RAM.
module seq_buffer
   import uart_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/uart_tx_sequencer.sv
// Replays a loadable byte buffer into a UART over tx_req/tx_ready; tx_req follows the accepted tx_ready by 4+gap cycles.
// Stalls in WAIT until tx_ready; a stuck UART trips the sticky timeout and returns to IDLE.
module uart_tx_sequencer
   import uart_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int GAP_W  = GAP_W_DEF,
   parameter int TMO_W  = TMO_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_mode,
   input  logic [ADDR_W:0]   length,
   input  logic [GAP_W-1:0]  gap,
   output logic              tx_req,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [ADDR_W-1:0] index,
   output logic [15:0]       pass_count
);
   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
   localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
   localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
   // One below all-ones: the counter reaches all-ones on the cycle we give up.
   localparam logic [TMO_W-1:0]  TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

   seq_state_t        state;
   logic [ADDR_W:0]   len_q;
   logic              loop_q;
   logic [GAP_W-1:0]  gap_q;
   logic [GAP_W-1:0]  gap_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              stop_q;
   logic [DATA_W-1:0] rd_data;
   logic              len_ok;
   logic              last_byte;

   assign len_ok    = (length != '0) && (length <= DEPTH_L);
   assign last_byte = ({1'b0, index} == (len_q - LEN_ONE));

   seq_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en && (state == IDLE)),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (index),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         tx_req     <= 1'b0;
         tx_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         index      <= '0;
         pass_count <= '0;
         gap_cnt    <= '0;
         tmo_cnt    <= '0;
         stop_q     <= 1'b0;
         len_q      <= '0;
         loop_q     <= 1'b0;
         gap_q      <= '0;
      end else begin
         tx_req <= 1'b0;
         done   <= 1'b0;
         if ((state != IDLE) && stop)
            stop_q <= 1'b1;

         case (state)
            IDLE: begin
               stop_q <= 1'b0;
               if (start && len_ok) begin
                  timeout    <= 1'b0;
                  index      <= '0;
                  pass_count <= '0;
                  len_q      <= length;
                  loop_q     <= loop_mode;
                  gap_q      <= gap;
                  busy       <= 1'b1;
                  state      <= FETCH;
               end
            end
            FETCH: state <= REQ;
            REQ: begin
               tx_req  <= 1'b1;
               tx_data <= rd_data;
               tmo_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               if (tx_ready) begin
                  state <= ADV;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_ONE;
                  if (tmo_cnt == TMO_LAST) begin
                     timeout <= 1'b1;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end
            ADV: begin
               if (last_byte)
                  pass_count <= pass_count + 16'd1;
               if (stop_q || (last_byte && !loop_q)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  index <= last_byte ? '0 : index + IDX_ONE;
                  if (gap_q == '0) begin
                     state <= FETCH;
                  end else begin
                     gap_cnt <= gap_q;
                     state   <= GAP;
                  end
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt - GAP_ONE;
               if (gap_cnt == GAP_ONE)
                  state <= FETCH;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: a transaction-level model (expected byte/index queue,
// spacing 4+gap, passes = bytes/length) is checked every cycle, plus hand-computed literal pins.
module tb_uart_tx_sequencer;
   localparam int DEPTH = 32;

   logic clk = 1'b0, reset = 1'b1;
   logic wr_en = 1'b0, start = 1'b0, stop = 1'b0, loop_mode = 1'b0, tx_ready = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [5:0] length = '0;
   logic [7:0] gap = '0;
   logic tx_req, busy, done, timeout;
   logic [7:0] tx_data;
   logic [4:0] index;
   logic [15:0] pass_count;

   always #5 clk = ~clk;

   uart_tx_sequencer #(.DATA_W(8), .DEPTH(DEPTH), .ADDR_W(5), .GAP_W(8), .TMO_W(4)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stop(stop), .loop_mode(loop_mode), .length(length), .gap(gap),
      .tx_req(tx_req), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy), .done(done),
      .timeout(timeout), .index(index), .pass_count(pass_count)
   );

   int tests = 0, fails = 0;
   logic [7:0] mem_m [DEPTH];
   int q_dat[$], q_idx[$];
   logic [7:0] sent[$];
   int cyc = 0, req_seen = 0, done_seen = 0, last_rdy = -1, last_space = -1;
   int exp_gap = 0, req_cyc = 0, tmo_cyc = 0;
   bit in_flight = 0, prev_req = 0, prev_tmo = 0, busy_ever = 0, uart_mute = 0;
   logic [7:0] held = '0;
   logic [7:0] t1 [23] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h64,
                           8'h65, 8'h72, 8'h67, 8'h20, 8'h77, 8'h61, 8'h73, 8'h20, 8'h68, 8'h65,
                           8'h72, 8'h65, 8'h2E};
   logic [7:0] pin2 [6] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE, 8'hAD};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle comparison against the expected transaction queue.
   always @(negedge clk) begin
      if (!reset) begin
         in_flight = 0;
         prev_req  = 0;
      end else begin
         cyc++;
         if (busy) busy_ever = 1;
         if (tx_req) begin
            req_seen++;
            req_cyc = cyc;
            sent.push_back(tx_data);
            if (q_dat.size() == 0) chk("unexpected_req", 1, 0);
            else begin
               chk("tx_data", tx_data, q_dat.pop_front());
               chk("index", index, q_idx.pop_front());
            end
            if (last_rdy >= 0) begin
               last_space = cyc - last_rdy;
               chk("req_spacing", last_space, 4 + exp_gap);
               last_rdy = -1;
            end
            chk("tx_req_one_cycle", prev_req, 0);
            in_flight = 1;
            held = tx_data;
         end else if (in_flight && busy) begin
            chk("tx_data_hold", tx_data, held);
         end
         if (tx_ready && in_flight) begin
            last_rdy  = cyc;
            in_flight = 0;
         end
         if (!busy) in_flight = 0;
         if (done) done_seen++;
         if (timeout && !prev_tmo) tmo_cyc = cyc;
         prev_tmo = timeout;
         prev_req = tx_req;
      end
   end

   // UART model: completion pulse 10 cycles after each request.
   initial forever begin
      @(negedge clk);
      if (reset && tx_req && !uart_mute) begin
         repeat (10) @(posedge clk);
         #1 tx_ready = 1'b1;
         @(posedge clk);
         #1 tx_ready = 1'b0;
      end
   end

   task automatic wr(input int a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a[4:0]; wr_data = d;
      @(posedge clk); #1 wr_en = 1'b0;
      mem_m[a] = d;
   endtask

   task automatic run_seq(input int len, input bit lp, input int g, input int stop_at,
                          input int total, input bit wr_busy);
      int lim;
      bit stopped, wrote;
      q_dat.delete(); q_idx.delete(); sent.delete();
      for (int i = 0; i < total; i++) begin
         q_dat.push_back(mem_m[i % len]);
         q_idx.push_back(i % len);
      end
      exp_gap = g; last_rdy = -1; done_seen = 0; req_seen = 0;
      length = len[5:0]; loop_mode = lp; gap = g[7:0]; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("timeout_cleared", timeout, 0);
      // later config changes must not disturb the running sequence
      length = 6'd1; loop_mode = ~lp; gap = 8'd0;
      lim = 0; stopped = 0; wrote = 0;
      while (busy && lim < 3000) begin
         @(negedge clk);
         lim++;
         if (stop_at > 0 && !stopped && req_seen == stop_at) begin
            @(posedge clk); #1 stop = 1'b1;
            @(posedge clk); #1 stop = 1'b0;
            stopped = 1;
         end
         if (wr_busy && !wrote && req_seen == 2) begin
            @(posedge clk); #1 wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h55;
            @(posedge clk); #1 wr_en = 1'b0;
            wrote = 1;
         end
      end
      chk("run_bound", lim < 3000, 1);
      @(posedge clk); @(negedge clk);
      chk("bytes_left", q_dat.size(), 0);
      chk("done_pulses", done_seen, 1);
      chk("pass_count", pass_count, total / len);
      chk("final_index", index, (total - 1) % len);
      chk("busy_end", busy, 0);
      chk("timeout_end", timeout, 0);
      @(posedge clk); #1;
   endtask

   task automatic bad_len(input int len);
      busy_ever = 0; req_seen = 0;
      length = len[5:0]; loop_mode = 1'b0; gap = '0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("bad_len_busy", busy_ever, 0);
      chk("bad_len_req", req_seen, 0);
   endtask

   task automatic chk_zero_outputs();
      chk("rst_tx_req", tx_req, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_index", index, 0);
      chk("rst_pass_count", pass_count, 0);
   endtask

   initial begin
      int lim;
      #3 reset = 1'b0;
      #1 chk_zero_outputs();
      #20;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < DEPTH; i++) wr(i, 8'(i * 7 + 3));

      // 1: 23-byte one-shot pass
      for (int i = 0; i < 23; i++) wr(i, t1[i]);
      run_seq(23, 0, 0, 0, 23, 0);
      chk("t1_count", sent.size(), 23);
      chk("t1_first", sent[0], 8'hDE);
      chk("t1_last", sent[22], 8'h2E);
      chk("t1_pass", pass_count, 1);

      // 2: loop mode with gap, stop during the 6th byte
      wr(0, 8'hDE); wr(1, 8'hAD); wr(2, 8'hBE); wr(3, 8'hEF);
      run_seq(4, 1, 3, 6, 6, 0);
      chk("t2_count", sent.size(), 6);
      for (int i = 0; i < 6; i++) chk("t2_byte", sent[i], pin2[i]);
      chk("t2_spacing", last_space, 7);

      // 3: UART never answers
      uart_mute = 1;
      q_dat.delete(); q_idx.delete();
      q_dat.push_back(mem_m[0]); q_idx.push_back(0);
      req_seen = 0; done_seen = 0; last_rdy = -1;
      length = 6'd1; loop_mode = 1'b0; gap = '0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      lim = 0;
      while (!timeout && lim < 200) begin @(posedge clk); #1; lim++; end
      chk("t3_bound", lim < 200, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("t3_timeout", timeout, 1);
      chk("t3_busy", busy, 0);
      chk("t3_no_done", done_seen, 0);
      chk("t3_wait_cycles", tmo_cyc - req_cyc, 15);
      uart_mute = 0;
      run_seq(1, 0, 0, 0, 1, 0);

      // 4: illegal lengths, then full depth one-shot and looped
      bad_len(0);
      bad_len(DEPTH + 1);
      run_seq(32, 0, 0, 0, 32, 0);
      chk("t4_index_no_wrap", index, 31);
      run_seq(32, 1, 0, 33, 33, 0);
      chk("t4_index_wrap", index, 0);

      // 5: writes ignored while busy, honoured in IDLE
      run_seq(8, 0, 0, 0, 8, 1);
      run_seq(8, 0, 0, 0, 8, 0);
      chk("t5_entry5_kept", sent[5], 8'h00);
      wr(5, 8'h55);
      run_seq(8, 0, 0, 0, 8, 0);
      chk("t5_entry5_new", sent[5], 8'h55);

      // 6: asynchronous reset in WAIT
      q_dat.delete(); q_idx.delete();
      for (int i = 0; i < 4; i++) begin q_dat.push_back(mem_m[i]); q_idx.push_back(i); end
      req_seen = 0; last_rdy = -1;
      length = 6'd4; loop_mode = 1'b1; gap = '0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      lim = 0;
      while (req_seen < 1 && lim < 100) begin @(posedge clk); #1; lim++; end
      chk("t6_bound", lim < 100, 1);
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      #1 chk_zero_outputs();
      @(posedge clk); #1 reset = 1'b1;
      q_dat.delete(); q_idx.delete();
      repeat (20) @(posedge clk);
      #1 chk("t6_idle_after_reset", busy, 0);
      run_seq(4, 0, 0, 0, 4, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
Parametrised byte-stream sequencer that replays a loadable buffer of bytes into a UART transmitter through the tx_req/tx_ready handshake. It generalises the fixed 32-entry send-once stimulus loop with:
- configurable depth, width and length;
- one-shot or loop mode, an inter-byte gap and a stop request;
- a handshake timeout.

It sits between a host/CPU register interface and a UART instance. It is used both in the programmer gateware and as a bench stimulus source.

Parameters:
DATA_W, 8, byte width of buffer and tx_data
DEPTH, 32, buffer entries (power of two, >=2)
ADDR_W, $clog2(DEPTH), buffer index width
GAP_W, 8, width of inter-byte gap counter
TMO_W, 16, width of tx_ready timeout counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe
wr_addr  in  ADDR_W  buffer write index
wr_data  in  DATA_W  buffer write data
start  in  1  begin sequence (sampled in IDLE only)
stop  in  1  finish current byte, then end
loop_mode  in  1  1 = restart at index 0 after last byte
length  in  ADDR_W+1  bytes per pass, 1..DEPTH
gap  in  GAP_W  idle cycles between bytes
tx_req  out  1  one-cycle request to UART
tx_data  out  DATA_W  byte presented with tx_req, held until tx_ready
tx_ready  in  1  UART one-cycle completion pulse
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on normal completion or stop
timeout  out  1  sticky error, cleared by next accepted start
index  out  ADDR_W  current buffer index
pass_count  out  16  completed passes, wraps at 0xFFFF

Behaviour:
- Reset (async, reset=0) clears the following and forces IDLE: tx_req, tx_data, busy, done, timeout, index, pass_count, the gap counter and the timeout counter.
- Buffer contents are not reset.
- Buffer is written synchronously. Writes are accepted in IDLE only and ignored while busy.
- Read latency is 1 cycle, registered.
- The configuration inputs (length, loop_mode, gap) are latched when start is accepted. Later changes have no effect until the next start.
- States:
  - IDLE: start=1 with length in 1..DEPTH -> clear timeout, index=0, pass_count=0, go to FETCH. start with length=0 or length>DEPTH -> ignored, stay IDLE.
  - FETCH: issue buffer read at index; next cycle go to REQ.
  - REQ: drive tx_data=buf[index] and tx_req=1 for exactly one cycle; go to WAIT.
  - WAIT: hold tx_data; the timeout counter increments each cycle.
    - tx_ready=1 -> go to ADV.
    - Counter reaches all-ones before tx_ready -> set timeout, go to IDLE. No done pulse.
  - ADV (1 cycle):
    - If stop was latched: done=1, go to IDLE.
    - Else if index==length-1: pass_count+1. Then either loop_mode=1 -> index=0, go to GAP; or loop_mode=0 -> done=1, go to IDLE.
    - Else index+1, go to GAP.
  - GAP: count gap cycles. gap=0 means a 0-cycle gap: ADV goes directly to FETCH.
- Request spacing with gap=0 is 4 cycles from tx_ready to the next tx_req (ADV, FETCH, then REQ; tx_req asserted in REQ).
- stop is latched while busy and cleared on entry to IDLE. A stop arriving in WAIT does not abort the byte in flight.
- Simultaneous stop and the last byte of a non-loop pass: single done pulse; pass_count still increments.
- Simultaneous start and stop in IDLE: start accepted; stop is not latched.
- A tx_ready outside WAIT is ignored.
- A reset deassertion mid-sequence resumes in IDLE. The UART owns its own abort.

Decomposition:
- Shared package uart_seq_pkg holds:
  - the state enum (IDLE, FETCH, REQ, WAIT, ADV, GAP);
  - localparam default widths.
- One sub-module, seq_buffer: a DEPTH x DATA_W simple dual-port RAM with a synchronous write and a registered read. It maps to block RAM.

Test Plan:
1. Load the 23 bytes DE AD BE EF 01 00 00 00 10 64 65 72 67 20 77 61 73 20 68 65 72 65 2E. Start with length=23, loop=0, gap=0, and the UART model echoing tx_ready after 10 cycles -> 23 tx_req pulses with the bytes in order, done pulses once, pass_count=1, busy low afterwards.
2. Loop mode, length=4, buffer DE AD BE EF, gap=3; assert stop during the 6th byte -> sequence DE AD BE EF DE AD, then done. pass_count=1. The gap between tx_ready and the next tx_req is 7 cycles.
3. UART model never returns tx_ready, TMO_W=4 -> timeout=1 after 15 WAIT cycles, busy=0, no done. The next start clears timeout.
4. start with length=0 and with length=DEPTH+1 -> no tx_req, busy stays 0. length=DEPTH sends all 32 entries, and index wraps to 0 only in loop mode.
5. Write wr_addr=5 with 0x55 while busy, then rerun -> entry 5 still holds its original value. The same write in IDLE takes effect on the next pass.
6. Pull reset low in WAIT, mid-byte -> all outputs go to 0 immediately (asynchronously). After release the block is in IDLE, and a new start replays from index 0.
